// File: rtl/rv32v_vfu_sequencer_pkg.sv
// Shared vector types for the VFU element sequencer: operation encoding,
// element width, sequencer states and the carry-op classifier.
package rv32v_vfu_sequencer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } vsew_t;

  typedef enum logic [1:0] {
    VFU_PASS_VS1 = 2'd0,
    VFU_ALU      = 2'd1,
    VFU_MUL      = 2'd2,
    VFU_DIV      = 2'd3
  } vfu_sel_t;

  typedef enum logic [3:0] {
    VALU_ADD   = 4'd0,
    VALU_SUB   = 4'd1,
    VALU_ADC   = 4'd2,
    VALU_SBC   = 4'd3,
    VALU_VMADC = 4'd4,
    VALU_VMSBC = 4'd5,
    VALU_MERGE = 4'd6,
    VALU_AND   = 4'd7
  } valu_op_t;

  typedef struct packed {
    vfu_sel_t vfu;
    valu_op_t alu;
  } vexec_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } vseq_state_t;

  localparam vexec_t VEXEC_NOP = '{vfu: VFU_PASS_VS1, alu: VALU_ADD};

  // Carry/merge ops consume v0 as data, so they never mask the element off.
  function automatic logic vop_uses_carry(input vexec_t op);
    logic carry;
    carry = 1'b0;
    if (op.vfu == VFU_ALU) begin
      case (op.alu)
        VALU_ADC, VALU_SBC, VALU_VMADC, VALU_VMSBC, VALU_MERGE: carry = 1'b1;
        default: carry = 1'b0;
      endcase
    end else begin
      carry = 1'b0;
    end
    return carry;
  endfunction

endpackage

// File: rtl/rv32v_seq_exec_reg.sv
// EXEC stage register of the element sequencer: holds the element currently
// presented to the VFU. Load wins over clear; an empty stage drives a NOP.
module rv32v_seq_exec_reg
  import rv32v_vfu_sequencer_pkg::*;
#(
  parameter int IDXW = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load,
  input  logic            clear,
  input  word_t           a_in,
  input  word_t           b_in,
  input  logic            mask_in,
  input  logic            active_in,
  input  vexec_t          vop_in,
  input  logic [IDXW-1:0] idx_in,
  output logic            valid,
  output word_t           a,
  output word_t           b,
  output logic            mask_bit,
  output logic            active,
  output vexec_t          vop,
  output logic [IDXW-1:0] idx
);

  // Pipeline register with load/hold/clear.
  always_ff @(posedge CLK) begin
    if (RST || (clear && !load)) begin
      valid    <= 1'b0;
      a        <= 32'd0;
      b        <= 32'd0;
      mask_bit <= 1'b1;
      active   <= 1'b0;
      vop      <= VEXEC_NOP;
      idx      <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      a        <= a_in;
      b        <= b_in;
      mask_bit <= mask_in;
      active   <= active_in;
      vop      <= vop_in;
      idx      <= idx_in;
    end else begin
      valid    <= valid;
      a        <= a;
      b        <= b;
      mask_bit <= mask_bit;
      active   <= active;
      vop      <= vop;
      idx      <= idx;
    end
  end

endmodule

// File: rtl/rv32v_vfu_sequencer.sv
// Vector element sequencer: walks elements vstart..vl-1 through a FETCH/EXEC
// pipe into the VFU and emits one writeback beat per active element.
module rv32v_vfu_sequencer
  import rv32v_vfu_sequencer_pkg::*;
#(
  parameter int MAX_VL = 32,
  parameter int IDXW   = $clog2(MAX_VL + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            flush,
  input  logic [IDXW-1:0] vl,
  input  logic [IDXW-1:0] vstart,
  input  logic            vm,
  input  vexec_t          vop_in,
  input  vsew_t           vsew_in,
  output logic [IDXW-1:0] rd_idx,
  input  word_t           rd_vs1,
  input  word_t           rd_vs2,
  input  logic            rd_v0,
  output word_t           vopA,
  output word_t           vopB,
  output logic            mask_bit,
  output vexec_t          vop,
  output vsew_t           vsew,
  input  word_t           vres,
  input  logic            vfu_stall,
  output logic            wb_en,
  output logic [IDXW-1:0] wb_idx,
  output word_t           wb_data,
  output logic            busy,
  output logic            done
);

  vseq_state_t     state_r, state_next;
  logic [IDXW-1:0] idx_r, vl_r;
  logic            vm_r, done_r, done_next;
  vexec_t          vop_r;
  vsew_t           vsew_r;
  logic            accept_s, transfer_s, retire_s, ex_clear_s, last_s;
  logic            fetch_carry_s, fetch_active_s, fetch_mask_s;
  logic            ex_valid, ex_active;
  logic [IDXW-1:0] ex_idx;
  logic            wb_en_r;
  logic [IDXW-1:0] wb_idx_r;
  word_t           wb_data_r;

  // Pipe handshakes and FSM next state.
  always_comb begin
    state_next     = state_r;
    fetch_carry_s  = vop_uses_carry(vop_r);
    fetch_active_s = vm_r | rd_v0 | fetch_carry_s;
    fetch_mask_s   = fetch_carry_s ? rd_v0 : ~fetch_active_s;
    accept_s       = start & ~flush & (state_r == SEQ_IDLE) & ~done_r;
    retire_s       = ex_valid & (~vfu_stall | ~ex_active);
    transfer_s     = ~flush & (state_r == SEQ_RUN) & (~ex_valid | retire_s);
    last_s         = (idx_r == (vl_r - {{(IDXW-1){1'b0}}, 1'b1}));
    ex_clear_s     = flush | (retire_s & ~transfer_s);
    done_next      = ~flush & (state_r == SEQ_DRAIN) & (~ex_valid | retire_s);
    case (state_r)
      SEQ_IDLE: begin
        if (accept_s) state_next = (vstart >= vl) ? SEQ_DRAIN : SEQ_RUN;
        else          state_next = SEQ_IDLE;
      end
      SEQ_RUN: begin
        if (transfer_s && last_s) state_next = SEQ_DRAIN;
        else                      state_next = SEQ_RUN;
      end
      SEQ_DRAIN: begin
        if (done_next) state_next = SEQ_IDLE;
        else           state_next = SEQ_DRAIN;
      end
      default: state_next = SEQ_IDLE;
    endcase
    if (flush) state_next = SEQ_IDLE;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= SEQ_IDLE;
    else     state_r <= state_next;
  end

  // Instruction fields and element index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_r  <= '0;
      vl_r   <= '0;
      vm_r   <= 1'b1;
      vop_r  <= VEXEC_NOP;
      vsew_r <= SEW8;
      done_r <= 1'b0;
    end else begin
      done_r <= done_next;
      if (accept_s) begin
        idx_r  <= vstart;
        vl_r   <= vl;
        vm_r   <= vm;
        vop_r  <= vop_in;
        vsew_r <= vsew_in;
      end else if (transfer_s) begin
        idx_r <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  rv32v_seq_exec_reg #(.IDXW(IDXW)) u_exec (
    .CLK       (CLK),
    .RST       (RST),
    .load      (transfer_s),
    .clear     (ex_clear_s),
    .a_in      (rd_vs1),
    .b_in      (rd_vs2),
    .mask_in   (fetch_mask_s),
    .active_in (fetch_active_s),
    .vop_in    (vop_r),
    .idx_in    (idx_r),
    .valid     (ex_valid),
    .a         (vopA),
    .b         (vopB),
    .mask_bit  (mask_bit),
    .active    (ex_active),
    .vop       (vop),
    .idx       (ex_idx)
  );

  // Writeback beat: one pulse per retiring active element.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_en_r   <= 1'b0;
      wb_idx_r  <= '0;
      wb_data_r <= 32'd0;
    end else if (retire_s && !flush) begin
      wb_en_r   <= ex_active;
      wb_idx_r  <= ex_idx;
      wb_data_r <= vres;
    end else begin
      wb_en_r   <= 1'b0;
      wb_idx_r  <= wb_idx_r;
      wb_data_r <= wb_data_r;
    end
  end

  assign rd_idx  = idx_r;
  assign vsew    = vsew_r;
  assign wb_en   = wb_en_r;
  assign wb_idx  = wb_idx_r;
  assign wb_data = wb_data_r;
  assign done    = done_r;
  assign busy    = (state_r != SEQ_IDLE) | done_r;

endmodule

// File: tb/tb_rv32v_vfu_sequencer.sv
// Directed bench for rv32v_vfu_sequencer: a behavioural register file and VFU,
// with a scoreboard of expected writeback beats and done timing.
module tb_rv32v_vfu_sequencer;
  import rv32v_vfu_sequencer_pkg::*;

  localparam int MAX_VL = 32;
  localparam int IDXW   = $clog2(MAX_VL + 1);

  logic            CLK = 1'b0;
  logic            RST, start, flush, vm, rd_v0, vfu_stall;
  logic [IDXW-1:0] vl, vstart, rd_idx, wb_idx;
  vexec_t          vop_in, vop;
  vsew_t           vsew_in, vsew;
  word_t           rd_vs1, rd_vs2, vopA, vopB, vres, wb_data;
  logic            mask_bit, wb_en, busy, done;

  rv32v_vfu_sequencer #(.MAX_VL(MAX_VL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .flush(flush), .vl(vl), .vstart(vstart),
    .vm(vm), .vop_in(vop_in), .vsew_in(vsew_in), .rd_idx(rd_idx), .rd_vs1(rd_vs1),
    .rd_vs2(rd_vs2), .rd_v0(rd_v0), .vopA(vopA), .vopB(vopB), .mask_bit(mask_bit),
    .vop(vop), .vsew(vsew), .vres(vres), .vfu_stall(vfu_stall), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  word_t vs1_mem [0:63];
  word_t vs2_mem [0:63];
  logic  v0_mem  [0:63];
  assign rd_vs1 = vs1_mem[rd_idx];
  assign rd_vs2 = vs2_mem[rd_idx];
  assign rd_v0  = v0_mem[rd_idx];

  // Behavioural VFU.
  always_comb begin
    vres = 32'd0;
    case (vop.vfu)
      VFU_PASS_VS1: vres = vopA;
      VFU_ALU: begin
        if (vop.alu == VALU_ADC) vres = vopA + vopB + {31'd0, mask_bit};
        else                     vres = vopA + vopB;
      end
      VFU_MUL: vres = vopA * vopB;
      default: vres = 32'd0;
    endcase
  end

  typedef struct {
    int    idx;
    word_t data;
    int    cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   edge_cnt = 0, t0 = 0, exp_done = -1, done_seen = 0;

  localparam vexec_t OP_ADD = '{vfu: VFU_ALU, alu: VALU_ADD};
  localparam vexec_t OP_ADC = '{vfu: VFU_ALU, alu: VALU_ADC};
  localparam vexec_t OP_MUL = '{vfu: VFU_MUL, alu: VALU_ADD};

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Writeback / done monitor against the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      if (wb_en) begin
        checks++;
        assert (sbq.size() != 0) else begin
          errors++; $error("FAIL wb_unexpected: idx %0d data %0d, required none", wb_idx, wb_data);
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checks++;
          assert (int'(wb_idx) === e.idx) else begin
            errors++; $error("FAIL wb_idx: got %0d, required %0d", wb_idx, e.idx);
          end
          checks++;
          assert (wb_data === e.data) else begin
            errors++; $error("FAIL wb_data idx %0d: got %0d, required %0d", e.idx, wb_data, e.data);
          end
          checks++;
          assert ((edge_cnt - t0) === e.cyc) else begin
            errors++; $error("FAIL wb_cycle idx %0d: got %0d, required %0d", e.idx, edge_cnt - t0, e.cyc);
          end
        end
      end
      if (done) begin
        done_seen = 1;
        checks++;
        assert ((edge_cnt - t0) === exp_done) else begin
          errors++; $error("FAIL done_cycle: got %0d, required %0d", edge_cnt - t0, exp_done);
        end
      end
    end
  end

  function automatic word_t model(input vexec_t op, input int i);
    case (op.vfu)
      VFU_MUL: return vs1_mem[i] * vs2_mem[i];
      VFU_ALU: return (op.alu == VALU_ADC) ? vs1_mem[i] + vs2_mem[i] + {31'd0, v0_mem[i]}
                                           : vs1_mem[i] + vs2_mem[i];
      default: return vs1_mem[i];
    endcase
  endfunction

  // Push expected beats, then pulse start for one cycle (returns in cycle 1).
  task automatic issue(input vexec_t op, input int l, input int s, input logic m, input int extra);
    logic carry;
    carry = (op.vfu == VFU_ALU) && (op.alu == VALU_ADC);
    for (int i = s; i < l; i++) begin
      if (m || v0_mem[i] || carry) sbq.push_back('{idx: i, data: model(op, i), cyc: 3 + (i - s) + extra});
    end
    exp_done  = (l > s) ? (3 + (l - s) - 1 + extra) : 2;
    done_seen = 0;
    @(posedge CLK); #1;
    vop_in = op; vsew_in = SEW32; vl = l[IDXW-1:0]; vstart = s[IDXW-1:0]; vm = m;
    start = 1'b1; t0 = edge_cnt;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge CLK); #2;
      n++;
    end
    checks++;
    assert (done_seen == 1) else begin
      errors++; $error("FAIL done_timeout: done not seen within %0d cycles", budget);
    end
    checks++;
    assert (sbq.size() == 0) else begin
      errors++; $error("FAIL beats_missing: %0d outstanding, required 0", sbq.size());
    end
    sbq.delete();
    repeat (2) @(posedge CLK);
  endtask

  task automatic chk(input string tag, input int got, input int req);
    checks++;
    assert (got === req) else begin
      errors++; $error("FAIL %s: got %0d, required %0d", tag, got, req);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; flush = 1'b0; vm = 1'b1; vfu_stall = 1'b0;
    vl = '0; vstart = '0; vop_in = VEXEC_NOP; vsew_in = SEW8;
    for (int i = 0; i < 64; i++) begin
      vs1_mem[i] = 32'(i); vs2_mem[i] = 32'd10; v0_mem[i] = 1'b0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_wb_idx", int'(wb_idx), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_vopA", int'(vopA), 0);
    chk("rst_mask_bit", int'(mask_bit), 1);
    chk("rst_vop", int'(vop), int'(VEXEC_NOP));
    chk("rst_vsew", int'(vsew), int'(SEW8));
    chk("rst_rd_idx", int'(rd_idx), 0);
    @(posedge CLK); #1; RST = 1'b0;

    // Plain add, 4 elements.
    issue(OP_ADD, 4, 0, 1'b1, 0);
    chk("busy_cycle1", int'(busy), 1);
    chk("rd_idx_cycle1", int'(rd_idx), 0);
    wait_done(20);
    chk("idle_after_add", int'(busy), 0);

    // Masked add: only elements 0 and 2 write back.
    v0_mem[0] = 1'b1; v0_mem[1] = 1'b0; v0_mem[2] = 1'b1; v0_mem[3] = 1'b0;
    issue(OP_ADD, 4, 0, 1'b0, 0);
    wait_done(20);

    // Add-with-carry: all elements written, v0 feeds the carry.
    for (int i = 0; i < 4; i++) begin
      vs1_mem[i] = 32'd5; vs2_mem[i] = 32'd7; v0_mem[i] = (i == 1);
    end
    issue(OP_ADC, 4, 0, 1'b0, 0);
    wait_done(20);

    // Multiply with 3 stall cycles on element 0.
    for (int i = 0; i < 4; i++) begin
      vs1_mem[i] = 32'(i + 2); vs2_mem[i] = 32'(3 * i + 1);
    end
    issue(OP_MUL, 4, 0, 1'b1, 3);
    @(posedge CLK); #1;
    vfu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rd_idx_frozen", int'(rd_idx), 1);
      @(posedge CLK); #1;
    end
    vfu_stall = 1'b0;
    wait_done(30);

    // Empty range: vstart == vl.
    issue(OP_ADD, 5, 5, 1'b1, 0);
    wait_done(10);

    // Flush after two beats, then a fresh instruction from vstart = 1.
    for (int i = 0; i < 4; i++) begin
      vs1_mem[i] = 32'(100 + i); vs2_mem[i] = 32'd1;
    end
    issue(OP_ADD, 4, 0, 1'b1, 0);
    sbq = sbq[0:1];
    exp_done = -1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    chk("flush_beats_left", sbq.size(), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_no_done", done_seen, 0);
    issue(OP_ADD, 3, 1, 1'b1, 0);
    wait_done(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
